// File: rtl/sigma_fetch_queue.sv
// Sigma CPU instruction prefetch: sequential word reads into a DEPTH-entry FIFO,
// head presented with pre-decoded opcode/R/indirect fields, plus branch redirect/flush.
module sigma_fetch_queue #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_addr,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [DATA_W-1:0]          inst_data,
    output logic [ADDR_W-1:0]          inst_addr,
    output logic [6:0]                 inst_opcode,
    output logic [3:0]                 inst_r,
    output logic                       inst_ia,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RST_A   = ADDR_W'(RESET_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fp_q, fp_d, fp_inc;
    logic               req_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               push, pop, has_space;
    logic [CNT_W-1:0]   count_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [ADDR_W-1:0]  addr_mem [DEPTH];

    // Head handshake: an entry transfers on a rising edge where inst_valid and
    // inst_ready are both high and redirect is low; a redirect cycle transfers nothing.
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready & ~redirect;
    assign push       = (state_q == S_WAIT) & mem_ack & ~redirect;
    assign count_next = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    assign has_space  = (count_next < DEPTH_C);
    assign fp_inc     = fp_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        fp_d    = redirect ? redirect_addr : fp_q;
        req_d   = mem_req;
        addr_d  = mem_addr;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    req_d   = 1'b1;
                    addr_d  = redirect_addr;
                    state_d = S_WAIT;
                end else if (has_space) begin
                    req_d   = 1'b1;
                    addr_d  = fp_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    if (redirect) begin
                        addr_d = redirect_addr;
                    end else begin
                        fp_d = fp_inc;
                        if (has_space) begin
                            addr_d = fp_inc;
                        end else begin
                            req_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The stale request must complete before the redirect target goes out.
                if (mem_ack) begin
                    if (redirect) begin
                        addr_d  = redirect_addr;
                        state_d = S_WAIT;
                    end else if (has_space) begin
                        addr_d  = fp_q;
                        state_d = S_WAIT;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fp_q     <= RST_A;
            mem_req  <= 1'b0;
            mem_addr <= RST_A;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state_q  <= state_d;
            fp_q     <= fp_d;
            mem_req  <= req_d;
            mem_addr <= addr_d;
            count    <= count_next;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_data;
            addr_mem[wr_ptr] <= mem_addr;
        end
    end

    // Fields read as zero whenever the FIFO is empty, so stale storage never leaks out.
    assign inst_data   = inst_valid ? data_mem[rd_ptr] : '0;
    assign inst_addr   = inst_valid ? addr_mem[rd_ptr] : '0;
    assign inst_ia     = inst_data[DATA_W-1];
    assign inst_opcode = inst_data[DATA_W-2 -: 7];
    assign inst_r      = inst_data[DATA_W-9 -: 4];
endmodule
